// File: rtl/xbar_pkg.sv
// Shared encodings and default widths for the round-robin crossbar slave.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int DEF_N_MASTERS  = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;

  // Width of a master index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, wrapping.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N     = DEF_N_MASTERS,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // Offset N lands back on last_grant itself, so a lone repeat requester still wins.
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(last_grant) + off) % N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: write and read both registered on the rising edge.
module sp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/xbar_slave_rr.sv
// Crossbar slave port: round-robin arbitration among masters in front of a small RAM.
module xbar_slave_rr
  import xbar_pkg::*;
#(
  parameter int N_MASTERS  = DEF_N_MASTERS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [N_MASTERS-1:0]            req,
  input  logic [N_MASTERS-1:0]            cmd,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] wdata,
  output logic [N_MASTERS-1:0]            ack,
  output logic [N_MASTERS*DATA_WIDTH-1:0] rdata,
  output logic                            busy
);

  localparam int IDX_W  = idx_width(N_MASTERS);
  localparam int RAM_AW = ADDR_WIDTH - 1;

  state_t                state;
  state_t                next_state;
  logic [IDX_W-1:0]      last_grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      arb_idx;
  logic [N_MASTERS-1:0]  arb_grant;
  logic                  cur_cmd;
  logic [RAM_AW-1:0]     cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [RAM_AW-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic                  unused_addr;

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // The address MSB selects this slave upstream and is never decoded here.
  assign sel_addr    = addr[int'(arb_idx)*ADDR_WIDTH +: RAM_AW];
  assign sel_wdata   = wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign unused_addr = ^addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_MASTERS - 1);
      grant_idx  <= '0;
      cur_cmd    <= CMD_READ;
      cur_addr   <= '0;
      cur_wdata  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && |arb_grant) begin
        grant_idx  <= arb_idx;
        last_grant <= arb_idx;
        cur_cmd    <= cmd[arb_idx];
        cur_addr   <= sel_addr;
        cur_wdata  <= sel_wdata;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = (|arb_grant) ? ACCESS : IDLE;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM works only on captured values, so dropping req mid-transaction is harmless.
  assign ram_we = (state == ACCESS) && (cur_cmd == CMD_WRITE);

  sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    ack   = '0;
    rdata = '0;
    if (state == RESP) begin
      ack[grant_idx] = 1'b1;
      if (cur_cmd == CMD_READ) begin
        rdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] = ram_rdata;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_xbar_slave_rr.sv
// Scoreboard bench for xbar_slave_rr: a transaction-level model predicts every ack,
// and negedge monitors compare whenever the DUT acknowledges.
module tb_xbar_slave_rr;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]    req, cmd, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic            busy;

  logic [3:0]   req4, cmd4, ack4;
  logic [15:0]  addr4;
  logic [127:0] wdata4, rdata4;
  logic         busy4;

  xbar_slave_rr #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .cmd(cmd), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy)
  );

  xbar_slave_rr #(.N_MASTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .req(req4), .cmd(cmd4), .addr(addr4),
    .wdata(wdata4), .ack(ack4), .rdata(rdata4), .busy(busy4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    int          cyc;
    logic [63:0] rdata;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   exp4_q[$];
  int   ack_log[$];

  logic [DW-1:0] mem [8];
  bit            known [8];
  int            m_last;
  int            mcount;
  int            n_granted;
  logic [N-1:0]  keep;
  bit            rand_mode;

  exp_t        mon_e;
  logic [63:0] mon_mask;
  int          mon_i;
  int          mon4_e;
  logic [127:0] mon4_mask;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int first_set(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    mcount = 0;
    exp_q.delete();
  endtask

  // One transaction occupies the slave for three edges; a new grant goes to
  // the next requester after the previous winner, wrapping around.
  task automatic model_edge();
    int   g;
    int   a;
    exp_t e;
    if (mcount != 0) begin
      mcount--;
      return;
    end
    if (req == '0) return;
    g = -1;
    for (int s = 1; s <= N; s++) begin
      if (g < 0 && req[(m_last + s) % N]) g = (m_last + s) % N;
    end
    a       = int'(addr[g*AW +: AW]) % 8;
    e.idx   = g;
    e.cyc   = cyc + 1;
    e.rdata = '0;
    e.chk   = 1'b1;
    if (cmd[g]) begin
      mem[a]   = wdata[g*DW +: DW];
      known[a] = 1'b1;
    end else begin
      e.chk = known[a];
      e.rdata[g*DW +: DW] = mem[a];
    end
    exp_q.push_back(e);
    m_last = g;
    mcount = 2;
    n_granted++;
  endtask

  task automatic start_req(input int i, input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd[i]           = c;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    req[i]           = 1'b1;
  endtask

  task automatic cycle_step();
    logic [N-1:0] acked;
    @(negedge clock);
    acked = ack;
    @(posedge clock);
    #1;
    model_edge();
    for (int i = 0; i < N; i++) begin
      if (acked[i] && !keep[i]) req[i] = 1'b0;
      if (rand_mode && req[i] == 1'b0 && $urandom_range(0, 2) == 0)
        start_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((req != '0 || mcount != 0 || exp_q.size() != 0) && n < 60) begin
      cycle_step();
      n++;
    end
    if (n >= 60) check("drain_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (mcount != 2 && n < 20) begin
      cycle_step();
      n++;
    end
    if (n >= 20) check("grant_timeout", 64'(n), 64'd0);
  endtask

  // Main-instance monitor.
  always @(negedge clock) begin
    if (reset_n) begin
      check("busy", 64'(busy), 64'(mcount != 0));
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          ack_log.push_back(first_set(ack));
          check("ack_onehot", 64'(ack), 64'd1 << mon_e.idx);
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (mon_e.chk) begin
            check("rdata", rdata, mon_e.rdata);
          end else begin
            mon_mask = 64'(32'hFFFF_FFFF) << (mon_e.idx * DW);
            check("rdata_other_slice", rdata & ~mon_mask, 64'd0);
          end
        end
      end else begin
        check("idle_rdata", rdata, 64'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          check("ack_missing", 64'(cyc), 64'(exp_q[0].cyc));
          mon_e = exp_q.pop_front();
        end
      end
    end
  end

  // Four-master instance monitor.
  always @(negedge clock) begin
    if (reset_n && ack4 != '0) begin
      if (exp4_q.size() == 0) begin
        check("dut4_unexpected_ack", 64'(ack4), 64'd0);
      end else begin
        mon4_e    = exp4_q.pop_front();
        mon4_mask = 128'(32'hFFFF_FFFF) << (mon4_e * 32);
        check("dut4_grant", 64'(ack4), 64'd1 << mon4_e);
        check("dut4_other_rdata", 64'(|(rdata4 & ~mon4_mask)), 64'd0);
        check("dut4_busy", 64'(busy4), 64'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int n4;
    reset_n = 1'b0;
    req = '0; cmd = '0; addr = '0; wdata = '0;
    req4 = '0; cmd4 = '0; addr4 = '0; wdata4 = '0;
    keep = '0; rand_mode = 1'b0; n_granted = 0;
    for (int i = 0; i < 8; i++) known[i] = 1'b0;
    model_reset();

    repeat (3) @(posedge clock);
    #1;
    check("reset_ack", 64'(ack), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ack4", 64'(ack4), 64'd0);
    reset_n = 1'b1;

    // Four masters, 1 and 3 requesting: first grant 1 moves the pointer to 1, then 3,1,3.
    exp4_q = '{1, 3, 1, 3};
    req4 = 4'b1010;
    n4 = 0;
    for (int t = 0; t < 40 && n4 < 4; t++) begin
      @(negedge clock);
      if (ack4 != '0) n4++;
    end
    @(posedge clock);
    #1 req4 = '0;
    check("dut4_ack_count", 64'(n4), 64'd4);
    repeat (2) @(posedge clock);
    #1 check("dut4_pending", 64'(exp4_q.size()), 64'd0);

    start_req(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    drain();
    start_req(1, 1'b0, 4'd3, 32'h0);
    drain();

    ack_log.delete();
    start_req(0, 1'b0, 4'd3, 32'h0);
    start_req(1, 1'b0, 4'd3, 32'h0);
    keep = 2'b11;
    n4 = n_granted + 4;
    for (int t = 0; t < 40 && n_granted < n4; t++) cycle_step();
    keep = '0;
    drain();
    check("order_len", 64'(ack_log.size() >= 4), 64'd1);
    if (ack_log.size() >= 4) begin
      check("order_0", 64'(ack_log[0]), 64'd0);
      check("order_1", 64'(ack_log[1]), 64'd1);
      check("order_2", 64'(ack_log[2]), 64'd0);
      check("order_3", 64'(ack_log[3]), 64'd1);
    end

    ack_log.delete();
    start_req(0, 1'b1, 4'd5, 32'h1234_5678);
    wait_grant();
    req[0] = 1'b0;
    drain();
    check("dropped_req_acked", 64'(ack_log.size()), 64'd1);
    start_req(1, 1'b0, 4'd5, 32'h0);
    drain();

    rand_mode = 1'b1;
    repeat (120) cycle_step();
    rand_mode = 1'b0;
    drain();

    start_req(1, 1'b0, 4'd2, 32'h0);
    wait_grant();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("abort_ack", 64'(ack), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rdata", rdata, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    ack_log.delete();
    start_req(0, 1'b0, 4'd3, 32'h0);
    drain();
    check("post_reset_count", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() >= 1) check("post_reset_first", 64'(ack_log[0]), 64'd0);

    repeat (2) @(posedge clock);
    #1 check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
